// File: rtl/mandel_frame_sched.sv
`default_nettype none
// ============================================================================
// Module   : mandel_frame_sched
// Brief    : Frame-level scheduler for the 4-lane Mandelbrot pipeline. Holds
//            shadow/active view configuration, steps the mapper one 4-pixel
//            group at a time, fires the escape-time engines, collects their
//            per-lane results and streams them out in pixel order.
// Options  : `define MANDEL_SCHED_PERF_EN adds the frame_cycles counter port.
// Revision : 1.0 - initial release
// ============================================================================
module mandel_frame_sched #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int ITER_W = 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  cfg_valid,
  input  logic [31:0]           cfg_zoom,
  input  logic [31:0]           cfg_re_lower,
  input  logic [31:0]           cfg_im_upper,
  input  logic                  start_frame,
  output logic [31:0]           zoom_factor,
  output logic [31:0]           re_lower,
  output logic [31:0]           im_upper,
  output logic                  map_en,
  output logic                  eng_start,
  input  logic [3:0]            eng_done,
  input  logic [4*ITER_W-1:0]   eng_iter,
  output logic [4*ITER_W-1:0]   m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic [9:0]            cur_x,
  output logic [9:0]            cur_y,
  output logic                  busy,
`ifdef MANDEL_SCHED_PERF_EN
  output logic [31:0]           frame_cycles,
`endif
  output logic                  frame_done
);

  localparam logic [9:0] C_X_LAST = 10'(WIDTH - 4);
  localparam logic [9:0] C_Y_LAST = 10'(HEIGHT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_OUT   = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         sh_zoom_q, sh_zoom_d, sh_re_q, sh_re_d, sh_im_q, sh_im_d;
  logic [31:0]         act_zoom_q, act_zoom_d, act_re_q, act_re_d, act_im_q, act_im_d;
  logic [9:0]          cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [3:0]          done_mask_q, done_mask_d;
  logic [4*ITER_W-1:0] result_q, result_d;

  // Next-state, datapath updates and per-state output strobes.
  always_comb begin
    state_d       = state_q;
    sh_zoom_d     = sh_zoom_q;
    sh_re_d       = sh_re_q;
    sh_im_d       = sh_im_q;
    act_zoom_d    = act_zoom_q;
    act_re_d      = act_re_q;
    act_im_d      = act_im_q;
    cur_x_d       = cur_x_q;
    cur_y_d       = cur_y_q;
    done_mask_d   = done_mask_q;
    result_d      = result_q;
    map_en        = 1'b0;
    eng_start     = 1'b0;
    frame_done    = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;

    // Shadow copy accepts writes at any time; LOAD reads the old value.
    if (cfg_valid) begin
      sh_zoom_d = cfg_zoom;
      sh_re_d   = cfg_re_lower;
      sh_im_d   = cfg_im_upper;
    end

    case (state_q)
      S_IDLE: begin
        if (start_frame) state_d = S_LOAD;
      end
      S_LOAD: begin
        act_zoom_d  = sh_zoom_q;
        act_re_d    = sh_re_q;
        act_im_d    = sh_im_q;
        cur_x_d     = '0;
        cur_y_d     = '0;
        done_mask_d = '0;
        state_d     = S_ISSUE;
      end
      S_ISSUE: begin
        eng_start   = 1'b1;
        done_mask_d = '0;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        // First done per lane wins; repeats on a captured lane are dropped.
        for (int i = 0; i < 4; i++) begin
          if (eng_done[i] && !done_mask_q[i]) begin
            result_d[i*ITER_W +: ITER_W] = eng_iter[i*ITER_W +: ITER_W];
            done_mask_d[i]               = 1'b1;
          end
        end
        if (done_mask_q == 4'hF) state_d = S_OUT;
      end
      S_OUT: begin
        m_axis_tvalid = 1'b1;
        m_axis_tuser  = (cur_x_q == 10'd0) && (cur_y_q == 10'd0);
        m_axis_tlast  = (cur_x_q == C_X_LAST);
        if (m_axis_tready) begin
          // Mapper counter advances in lock-step with cur_x/cur_y.
          map_en = 1'b1;
          if (cur_x_q != C_X_LAST) begin
            cur_x_d = cur_x_q + 10'd4;
            state_d = S_ISSUE;
          end else begin
            cur_x_d = '0;
            if (cur_y_q != C_Y_LAST) begin
              cur_y_d = cur_y_q + 10'd1;
              state_d = S_ISSUE;
            end else begin
              cur_y_d = '0;
              state_d = S_FIN;
            end
          end
        end
      end
      S_FIN: begin
        frame_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      sh_zoom_q   <= '0;
      sh_re_q     <= '0;
      sh_im_q     <= '0;
      act_zoom_q  <= '0;
      act_re_q    <= '0;
      act_im_q    <= '0;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      done_mask_q <= '0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      sh_zoom_q   <= sh_zoom_d;
      sh_re_q     <= sh_re_d;
      sh_im_q     <= sh_im_d;
      act_zoom_q  <= act_zoom_d;
      act_re_q    <= act_re_d;
      act_im_q    <= act_im_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      done_mask_q <= done_mask_d;
      result_q    <= result_d;
    end
  end

  assign zoom_factor  = act_zoom_q;
  assign re_lower     = act_re_q;
  assign im_upper     = act_im_q;
  assign cur_x        = cur_x_q;
  assign cur_y        = cur_y_q;
  assign m_axis_tdata = result_q;
  assign busy         = (state_q != S_IDLE);

`ifdef MANDEL_SCHED_PERF_EN
  logic [31:0] frame_cycles_q, frame_cycles_d;

  // Busy-cycle counter: cleared by LOAD, saturating, held while idle.
  always_comb begin
    frame_cycles_d = frame_cycles_q;
    if (state_q == S_LOAD) begin
      frame_cycles_d = '0;
    end else if (busy && (frame_cycles_q != 32'hFFFF_FFFF)) begin
      frame_cycles_d = frame_cycles_q + 32'd1;
    end
  end

  // Counter register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) frame_cycles_q <= '0;
    else          frame_cycles_q <= frame_cycles_d;
  end

  assign frame_cycles = frame_cycles_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mandel_frame_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_mandel_frame_sched
// Brief    : Scoreboard bench for mandel_frame_sched (WIDTH=8, HEIGHT=2).
//            An engine model answers each eng_start and queues the expected
//            beat; a monitor pops and compares on every output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mandel_frame_sched;
  localparam int W   = 8;
  localparam int H   = 2;
  localparam int IW  = 8;
  localparam int GPL = W / 4;
  localparam int GPF = GPL * H;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [31:0]   cfg_zoom = '0, cfg_re_lower = '0, cfg_im_upper = '0;
  logic          start_frame = 1'b0;
  logic [31:0]   zoom_factor, re_lower, im_upper;
  logic          map_en, eng_start;
  logic [3:0]    eng_done = '0;
  logic [4*IW-1:0] eng_iter = '0;
  logic [4*IW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tuser;
  logic          m_axis_tready = 1'b1;
  logic [9:0]    cur_x, cur_y;
  logic          busy, frame_done;
`ifdef MANDEL_SCHED_PERF_EN
  logic [31:0]   frame_cycles;
`endif

  mandel_frame_sched #(.WIDTH(W), .HEIGHT(H), .ITER_W(IW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cfg_valid(cfg_valid), .cfg_zoom(cfg_zoom),
    .cfg_re_lower(cfg_re_lower), .cfg_im_upper(cfg_im_upper),
    .start_frame(start_frame),
    .zoom_factor(zoom_factor), .re_lower(re_lower), .im_upper(im_upper),
    .map_en(map_en), .eng_start(eng_start),
    .eng_done(eng_done), .eng_iter(eng_iter),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser),
    .cur_x(cur_x), .cur_y(cur_y), .busy(busy),
`ifdef MANDEL_SCHED_PERF_EN
    .frame_cycles(frame_cycles),
`endif
    .frame_done(frame_done)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] data;
    logic        user;
    logic        last;
    logic [9:0]  x;
    logic [9:0]  y;
  } beat_t;

  beat_t       exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          eng_mode = 0;    // 0 random, 1 all lanes at 3, 2 out-of-order, 3 slow
  int          ready_mode = 0;  // 0 always ready, 1 random, 2 driven by main
  int          grp = 0;
  int          beats = 0;
  int          map_en_cnt = 0;
  int          hs_total = 0;
  logic [31:0] last_hs_data = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Engine model: answers one group per eng_start and queues the expected beat.
  task automatic run_group();
    int d[4];
    logic [7:0] it[4];
    int maxd, dup_lane, dup_d;
    bit dup;
    beat_t b;
    maxd = 0;
    for (int i = 0; i < 4; i++) begin
      it[i] = 8'($urandom);
      case (eng_mode)
        1: d[i] = 3;
        3: d[i] = 10;
        default: d[i] = $urandom_range(1, 6);
      endcase
    end
    if (eng_mode == 2) begin
      d[2] = 1; d[0] = 2; d[3] = 3; d[1] = 4;
      it[0] = 8'd5; it[1] = 8'd9; it[2] = 8'd200; it[3] = 8'd1;
    end
    for (int i = 0; i < 4; i++) if (d[i] > maxd) maxd = d[i];
    dup_lane = (eng_mode == 2) ? 0 : int'($urandom_range(0, 3));
    dup = (eng_mode == 2) || (eng_mode == 0 && $urandom_range(0, 1) == 1 && d[dup_lane] < maxd);
    dup_d = (eng_mode == 2) ? 3 : (dup ? int'($urandom_range(d[dup_lane] + 1, maxd)) : 0);

    b.data = {it[3], it[2], it[1], it[0]};
    b.x    = 10'((grp % GPL) * 4);
    b.y    = 10'(grp / GPL);
    b.user = (grp == 0);
    b.last = ((grp % GPL) == GPL - 1);
    exp_q.push_back(b);
    grp = (grp + 1) % GPF;

    for (int t = 1; t <= maxd; t++) begin
      @(posedge aclk); #1;
      if (!aresetn) begin eng_done = '0; return; end
      eng_done = '0;
      eng_iter = $urandom;
      for (int i = 0; i < 4; i++) begin
        if (d[i] == t) begin
          eng_done[i] = 1'b1;
          eng_iter[i*IW +: IW] = it[i];
        end
      end
      if (dup && t == dup_d) begin
        eng_done[dup_lane] = 1'b1;
        eng_iter[dup_lane*IW +: IW] = (eng_mode == 2) ? 8'd77 : ~it[dup_lane];
      end
    end
    @(posedge aclk); #1;
    eng_done = '0;
  endtask

  initial begin
    forever begin
      @(negedge aclk);
      if (aresetn && eng_start) run_group();
    end
  end

  // Downstream ready generator.
  initial begin
    forever begin
      @(posedge aclk); #1;
      if (ready_mode == 0) m_axis_tready = 1'b1;
      else if (ready_mode == 1) m_axis_tready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: scoreboard pop on handshake plus stall/latency protocol checks.
  initial begin
    bit prev_stall = 0, exp_fd = 0, exp_es = 0;
    logic [34:0] prev_out = '0;
    beat_t b;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        prev_stall = 0; exp_fd = 0; exp_es = 0;
        continue;
      end
      if (exp_fd) chk("frame_done_after_last", 128'(frame_done), 128'(1'b1));
      if (exp_es) chk("eng_start_after_hs", 128'(eng_start), 128'(1'b1));
      exp_fd = 0; exp_es = 0;
      if (prev_stall)
        chk("stall_hold", 128'({m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast}),
            128'({1'b1, prev_out[33:0]}));
      if (m_axis_tvalid || map_en)
        chk("map_en", 128'(map_en), 128'(m_axis_tvalid && m_axis_tready));
      if (map_en) map_en_cnt++;
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          chk("beat_unexpected", 128'(1'b1), 128'(1'b0));
        end else begin
          b = exp_q.pop_front();
          chk("beat_data", 128'(m_axis_tdata), 128'(b.data));
          chk("beat_user_last_xy", 128'({m_axis_tuser, m_axis_tlast, cur_x, cur_y}),
              128'({b.user, b.last, b.x, b.y}));
          if (b.x == 10'(W - 4) && b.y == 10'(H - 1)) exp_fd = 1;
          else exp_es = 1;
        end
        beats++;
        hs_total++;
        last_hs_data = m_axis_tdata;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_out   = {m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast};
      if (frame_done) begin
        chk("frame_beats", 128'(beats), 128'(GPF));
        chk("frame_map_en", 128'(map_en_cnt), 128'(GPF));
        beats = 0; map_en_cnt = 0;
      end
    end
  end

  task automatic pulse_start();
    @(posedge aclk); #1 start_frame = 1'b1;
    @(posedge aclk); #1 start_frame = 1'b0;
  endtask

  task automatic write_cfg(input logic [31:0] z, input logic [31:0] r, input logic [31:0] i);
    @(posedge aclk); #1;
    cfg_valid = 1'b1; cfg_zoom = z; cfg_re_lower = r; cfg_im_upper = i;
    @(posedge aclk); #1 cfg_valid = 1'b0;
  endtask

  task automatic wait_frame_done();
    int n = 0;
    while (n < 1000) begin
      @(negedge aclk);
      if (frame_done) break;
      n++;
    end
    if (n >= 1000) chk("frame_done_timeout", 128'(1'b0), 128'(1'b1));
    @(negedge aclk);
    chk("idle_after_frame", 128'(busy), 128'(1'b0));
  endtask

  task automatic wait_hs();
    int start_cnt = hs_total;
    int n = 0;
    while (hs_total == start_cnt && n < 500) begin
      @(negedge aclk); #1;
      n++;
    end
    if (n >= 500) chk("handshake_timeout", 128'(1'b0), 128'(1'b1));
  endtask

  task automatic wait_tvalid();
    int n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (!m_axis_tvalid && n < 500);
    if (n >= 500) chk("tvalid_timeout", 128'(1'b0), 128'(1'b1));
  endtask

  initial begin
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("reset_cfg_out", 128'({zoom_factor, re_lower, im_upper}), 128'(0));
    chk("reset_ctrl", 128'({m_axis_tvalid, m_axis_tuser, m_axis_tlast, map_en,
                            eng_start, busy, frame_done, cur_x, cur_y, m_axis_tdata}), 128'(0));
    aresetn = 1'b1;

    // Config and start latency.
    eng_mode = 1; ready_mode = 0;
    write_cfg(32'h0000_1000, 32'hFF00_0000, 32'h0080_0000);
    @(negedge aclk);
    chk("shadow_not_active", 128'(zoom_factor), 128'(0));
    pulse_start();
    @(negedge aclk);
    chk("load_no_eng_start", 128'({eng_start, busy}), 128'({1'b0, 1'b1}));
    @(negedge aclk);
    chk("eng_start_latency", 128'(eng_start), 128'(1'b1));
    chk("active_cfg", 128'({zoom_factor, re_lower, im_upper}),
        128'({32'h0000_1000, 32'hFF00_0000, 32'h0080_0000}));
    wait_frame_done();

    // Out-of-order lanes with a duplicate done on lane 0.
    eng_mode = 2;
    pulse_start();
    wait_hs();
    chk("ooo_tdata", 128'(last_hs_data), 128'(32'h01C8_0905));
    wait_frame_done();

    // Downstream stall during OUT.
    eng_mode = 1; ready_mode = 2; m_axis_tready = 1'b0;
    pulse_start();
    wait_tvalid();
    repeat (5) begin
      @(negedge aclk);
      chk("stall_valid_no_map_en", 128'({m_axis_tvalid, map_en}), 128'({1'b1, 1'b0}));
    end
    @(posedge aclk); #1 m_axis_tready = 1'b1; ready_mode = 0;
    wait_frame_done();

    // Mid-frame cfg write and ignored second start.
    eng_mode = 0; ready_mode = 1;
    pulse_start();
    repeat (3) @(negedge aclk);
    write_cfg(32'h0000_2000, 32'h1111_1111, 32'h2222_2222);
    @(negedge aclk);
    chk("mid_frame_zoom_held", 128'(zoom_factor), 128'(32'h0000_1000));
    pulse_start();
    wait_frame_done();
    chk("zoom_held_after_frame", 128'(zoom_factor), 128'(32'h0000_1000));
    repeat (3) @(negedge aclk);
    chk("second_start_ignored", 128'(busy), 128'(1'b0));

    // cfg_valid in the LOAD cycle: LOAD keeps the pre-write shadow.
    @(posedge aclk); #1 start_frame = 1'b1;
    @(posedge aclk); #1 start_frame = 1'b0;
    cfg_valid = 1'b1; cfg_zoom = 32'h0000_3000;
    @(posedge aclk); #1 cfg_valid = 1'b0;
    @(negedge aclk);
    chk("load_collision_zoom", 128'(zoom_factor), 128'(32'h0000_2000));
    wait_frame_done();
    pulse_start();
    repeat (2) @(negedge aclk);
    chk("next_frame_zoom", 128'(zoom_factor), 128'(32'h0000_3000));
    wait_frame_done();

    // Random frames.
    for (int f = 0; f < 6; f++) begin
      pulse_start();
      wait_frame_done();
    end

    // Reset asserted while waiting on group 2.
    eng_mode = 3; ready_mode = 0;
    pulse_start();
    begin
      int n = 0;
      while (grp != 3 && n < 500) begin @(negedge aclk); n++; end
      if (n >= 500) chk("group2_timeout", 128'(1'b0), 128'(1'b1));
    end
    repeat (3) @(negedge aclk);
    aresetn = 1'b0;
    #1;
    chk("midreset_ctrl", 128'({m_axis_tvalid, m_axis_tuser, m_axis_tlast, map_en,
                               eng_start, busy, frame_done, cur_x, cur_y, m_axis_tdata}), 128'(0));
    chk("midreset_cfg", 128'({zoom_factor, re_lower, im_upper}), 128'(0));
    repeat (2) @(negedge aclk);
    exp_q.delete(); grp = 0; beats = 0; map_en_cnt = 0;
    aresetn = 1'b1;
    eng_mode = 1;
    pulse_start();
    wait_tvalid();
    chk("post_reset_first_beat", 128'({m_axis_tuser, cur_x, cur_y}), 128'({1'b1, 10'd0, 10'd0}));
    wait_frame_done();

    repeat (3) @(negedge aclk);
    chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
